// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Access sizes and FSM state type.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_logic.sv
// Little-endian lane extract/extend for loads and lane merge for
// sub-word stores; purely combinational.
module lsu_lane_logic
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] sdata,
    output logic [31:0] load_val,
    output logic [31:0] store_word
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v     = word[{off, 3'b000} +: 8];
        half_v     = off[1] ? word[31:16] : word[15:0];
        load_val   = word;
        store_word = sdata;
        unique case (size)
            SZ_BYTE: begin
                load_val   = {{24{~uns & byte_v[7]}}, byte_v};
                store_word = word;
                store_word[{off, 3'b000} +: 8] = sdata[7:0];
            end
            SZ_HALF: begin
                load_val   = {{16{~uns & half_v[15]}}, half_v};
                store_word = word;
                if (off[1]) store_word[31:16] = sdata[15:0];
                else        store_word[15:0]  = sdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit in front of the unified memory;
// sub-word stores go through a read-modify-write MERGE step.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 2048,
    parameter int unsigned DATA_BASE = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        fault;
    logic        sub_store;
    logic [31:0] lane_word;
    logic [31:0] load_val;
    logic [31:0] store_word;

    assign accept    = req && ready;
    assign sub_store = we_q && (size_q != SZ_WORD);
    assign lane_word = (state_q == MERGE) ? merge_q : mem_rdata;

    // Any of these blocks the memory access entirely.
    assign fault = (size == 2'b11)
                || (size == SZ_HALF && addr[0])
                || (size == SZ_WORD && addr[1:0] != 2'b00)
                || (addr >= MEM_BYTES)
                || (we && addr < DATA_BASE);

    lsu_lane_logic u_lane (
        .word       (lane_word),
        .off        (addr_q[1:0]),
        .size       (size_q),
        .uns        (uns_q),
        .sdata      (wdata_q),
        .load_val   (load_val),
        .store_word (store_word)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = fault ? RESP : ACCESS;
            ACCESS:  state_d = sub_store ? MERGE : RESP;
            MERGE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state_q == IDLE);
        done      = (state_q == RESP);
        rdata     = rdata_q;
        err       = err_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_we    = !reset && ((state_q == ACCESS && we_q && !sub_store)
                               || state_q == MERGE);
        mem_wdata = mem_we ? store_word : 32'd0;
    end

    // rdata/err only change on the edge that enters RESP.
    always_comb begin
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        merge_d = merge_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (accept) begin
                we_d    = we;
                size_d  = size;
                uns_d   = uns;
                addr_d  = addr;
                wdata_d = wdata;
                if (fault) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_val;
                    err_d   = 1'b0;
                end else if (!sub_store) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                end else begin
                    merge_d = mem_rdata;
                end
            end
            MERGE: begin
                rdata_d = 32'd0;
                err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            merge_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural 512x32
// memory; expected responses are queued at issue and popped on done.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset, req, we, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    logic        ready, done, err, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [512];

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int we_cnt = 0, acc_cnt = 0, done_cnt = 0;

    load_store_unit dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .ready     (ready),
        .we        (we),
        .size      (size),
        .uns       (uns),
        .addr      (addr),
        .wdata     (wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[10:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[10:2]] <= mem_wdata;
        if (mem_we) we_cnt++;
        if (req && ready) acc_cnt++;
        if (done) done_cnt++;
    end

    // Drive one request at a negedge; returns at the negedge after the
    // accept edge.  Inputs are scrambled afterwards unless held.
    task automatic issue(input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd,
                         input logic er, input int lat, input bit hold);
        exp_t e;
        e.rd = rd; e.er = er; e.lat = lat;
        sb.push_back(e);
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        @(negedge clk);
        if (!hold) begin
            req   = 1'b0;
            we    = 1'($urandom);
            addr  = $urandom;
            wdata = $urandom;
        end
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00;
        uns = 1'b0; addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total += 7;
        if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
        if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        if (mem_addr !== 32'd0) begin bad++; $display("FAIL rst_mem_addr got=%h want=0", mem_addr); end
        if (mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_wdata got=%h want=0", mem_wdata); end
    endtask

    task automatic test_load_word();
        int cyc, w0;
        exp_t e;
        w0 = we_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'd1200, 32'd0, 32'h8899AABB, 1'b0, 2, 1'b0);
        wait_done(cyc);
        e = sb.pop_front();
        total += 4;
        if (!done || cyc != e.lat) begin bad++; $display("FAIL lw_lat got=%0d want=%0d", cyc, e.lat); end
        if (rdata !== e.rd) begin bad++; $display("FAIL lw_rdata got=%h want=%h", rdata, e.rd); end
        if (err !== e.er) begin bad++; $display("FAIL lw_err got=%b want=%b", err, e.er); end
        if (we_cnt != w0) begin bad++; $display("FAIL lw_mem_we got=%0d want=0", we_cnt - w0); end
        @(negedge clk);
    endtask

    task automatic test_load_ext();
        logic [31:0] a_t [3] = '{32'd1201, 32'd1201, 32'd1202};
        logic [1:0]  s_t [3] = '{2'b00, 2'b00, 2'b01};
        logic        u_t [3] = '{1'b0, 1'b1, 1'b0};
        logic [31:0] r_t [3] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899};
        int cyc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, s_t[i], u_t[i], a_t[i], 32'd0, r_t[i], 1'b0, 2, 1'b0);
            wait_done(cyc);
            e = sb.pop_front();
            total += 3;
            if (!done || cyc != e.lat) begin bad++; $display("FAIL ext%0d_lat got=%0d want=%0d", i, cyc, e.lat); end
            if (rdata !== e.rd) begin bad++; $display("FAIL ext%0d_rdata got=%h want=%h", i, rdata, e.rd); end
            if (err !== e.er) begin bad++; $display("FAIL ext%0d_err got=%b want=%b", i, err, e.er); end
            @(negedge clk);
        end
    endtask

    task automatic test_store_byte();
        int cyc, w0;
        exp_t e;
        w0 = we_cnt;
        issue(1'b1, 2'b00, 1'b0, 32'd1203, 32'h12345677, 32'd0, 1'b0, 3, 1'b0);
        total += 2;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL sb_we_access got=%b want=0", mem_we); end
        @(negedge clk);
        if (mem_we !== 1'b1) begin bad++; $display("FAIL sb_we_merge got=%b want=1", mem_we); end
        wait_done(cyc);
        cyc++;
        e = sb.pop_front();
        total += 5;
        if (!done || cyc != e.lat) begin bad++; $display("FAIL sb_lat got=%0d want=%0d", cyc, e.lat); end
        if (rdata !== e.rd) begin bad++; $display("FAIL sb_rdata got=%h want=%h", rdata, e.rd); end
        if (err !== e.er) begin bad++; $display("FAIL sb_err got=%b want=%b", err, e.er); end
        if (we_cnt - w0 != 1) begin bad++; $display("FAIL sb_we_cnt got=%0d want=1", we_cnt - w0); end
        if (mem[300] !== 32'h7799AABB) begin bad++; $display("FAIL sb_mem got=%h want=7799aabb", mem[300]); end
        @(negedge clk);
    endtask

    task automatic test_faults();
        logic        w_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  s_t [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
        logic [31:0] a_t [4] = '{32'd1201, 32'd8, 32'd2048, 32'd1200};
        int cyc, w0;
        logic [31:0] m300, m2;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            w0 = we_cnt; m300 = mem[300]; m2 = mem[2];
            issue(w_t[i], s_t[i], 1'b0, a_t[i], 32'hCAFEF00D, 32'd0, 1'b1, 1, 1'b0);
            wait_done(cyc);
            e = sb.pop_front();
            total += 5;
            if (!done || cyc != e.lat) begin bad++; $display("FAIL flt%0d_lat got=%0d want=%0d", i, cyc, e.lat); end
            if (err !== e.er) begin bad++; $display("FAIL flt%0d_err got=%b want=%b", i, err, e.er); end
            if (rdata !== e.rd) begin bad++; $display("FAIL flt%0d_rdata got=%h want=%h", i, rdata, e.rd); end
            if (we_cnt != w0) begin bad++; $display("FAIL flt%0d_mem_we got=%0d want=0", i, we_cnt - w0); end
            if (mem[300] !== m300 || mem[2] !== m2) begin
                bad++;
                $display("FAIL flt%0d_mem got=%h/%h want=%h/%h", i, mem[300], mem[2], m300, m2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_merge();
        int w0, d0;
        logic [31:0] m300;
        w0 = we_cnt; d0 = done_cnt; m300 = mem[300];
        req = 1'b1; we = 1'b1; size = 2'b01; uns = 1'b0;
        addr = 32'd1200; wdata = 32'h00005555;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        total += 1;
        if (mem_we !== 1'b0) begin bad++; $display("FAIL rm_mem_we got=%b want=0", mem_we); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total += 5;
        if (ready !== 1'b1) begin bad++; $display("FAIL rm_ready got=%b want=1", ready); end
        if (done !== 1'b0) begin bad++; $display("FAIL rm_done got=%b want=0", done); end
        if (done_cnt != d0) begin bad++; $display("FAIL rm_done_cnt got=%0d want=0", done_cnt - d0); end
        if (we_cnt != w0) begin bad++; $display("FAIL rm_we_cnt got=%0d want=0", we_cnt - w0); end
        if (mem[300] !== m300) begin bad++; $display("FAIL rm_mem got=%h want=%h", mem[300], m300); end
    endtask

    task automatic test_back_to_back();
        int cyc, a0;
        exp_t e;
        issue(1'b1, 2'b10, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b0);
        wait_done(cyc);
        e = sb.pop_front();
        total += 3;
        if (!done || cyc != e.lat) begin bad++; $display("FAIL b2b_st_lat got=%0d want=%0d", cyc, e.lat); end
        if (err !== e.er) begin bad++; $display("FAIL b2b_st_err got=%b want=%b", err, e.er); end
        if (mem[256] !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_mem got=%h want=deadbeef", mem[256]); end
        @(negedge clk);
        a0 = acc_cnt;
        issue(1'b0, 2'b10, 1'b0, 32'd1024, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b1);
        wait_done(cyc);
        req = 1'b0;
        e = sb.pop_front();
        total += 3;
        if (!done || cyc != e.lat) begin bad++; $display("FAIL b2b_ld_lat got=%0d want=%0d", cyc, e.lat); end
        if (rdata !== e.rd) begin bad++; $display("FAIL b2b_ld_rdata got=%h want=%h", rdata, e.rd); end
        if (err !== e.er) begin bad++; $display("FAIL b2b_ld_err got=%b want=%b", err, e.er); end
        @(negedge clk);
        total += 2;
        if (acc_cnt - a0 != 1) begin bad++; $display("FAIL b2b_accepts got=%0d want=1", acc_cnt - a0); end
        if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_hold got=%h want=deadbeef", rdata); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 32'd0;
        mem[300] = 32'h8899AABB;
        mem[2]   = 32'h0BADF00D;
        @(negedge clk);
        test_reset();
        test_load_word();
        test_load_ext();
        test_store_byte();
        test_faults();
        test_reset_merge();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
